// File: rtl/if_pc_sequencer.sv
// Fetch-stage PC owner: sequences fetch requests, applies EX branch redirects and buffers one
// fetched instruction toward IF/ID. Define IF_MISALIGN_TRAP_EN to trap on misaligned targets.
module if_pc_sequencer #(
    parameter int unsigned      XLEN        = 64,
    parameter logic [XLEN-1:0]  RESET_PC    = '0,
    parameter int unsigned      INSTR_BYTES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] br_imm,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_pc,
    output logic [31:0]     ifid_instr,
    input  logic            ifid_ready,
    output logic            flush_out,
    output logic            misalign
);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_REDIR = 2'd2;
`ifdef IF_MISALIGN_TRAP_EN
    localparam logic [1:0] ST_TRAP  = 2'd3;
`endif

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] target;
    logic            ifid_valid_nxt;
    logic [XLEN-1:0] ifid_pc_nxt;
    logic [31:0]     ifid_instr_nxt;
    logic            flush_nxt;
    logic            redirect;
    logic            accept;

    // Halfword-scaled immediate; carry out of XLEN is dropped.
    assign target    = br_pc + (br_imm << 1);
    assign imem_req  = ~reset & (state == ST_RUN) & ~stall & ~br_taken & (~ifid_valid | ifid_ready);
    assign imem_addr = pc;
    assign accept    = imem_req & imem_ready;

`ifdef IF_MISALIGN_TRAP_EN
    assign redirect = br_taken & (state != ST_TRAP);
`else
    assign redirect = br_taken;
`endif

    // Next-state and next-value logic for all sequencer registers.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        ifid_valid_nxt = ifid_valid;
        ifid_pc_nxt    = ifid_pc;
        ifid_instr_nxt = ifid_instr;
        flush_nxt      = 1'b0;

        case (state)
            ST_BOOT:  state_nxt = ST_RUN;
            ST_RUN:   state_nxt = ST_RUN;
            ST_REDIR: state_nxt = ST_RUN;
            default:  state_nxt = state;
        endcase

        if (redirect) begin
            state_nxt      = ST_REDIR;
            pc_nxt         = target;
            ifid_valid_nxt = 1'b0;
            flush_nxt      = 1'b1;
`ifdef IF_MISALIGN_TRAP_EN
            if (target[1:0] != 2'b00) begin
                state_nxt = ST_TRAP;
            end
`endif
        end else if (accept) begin
            pc_nxt         = pc + XLEN'(INSTR_BYTES);
            ifid_valid_nxt = 1'b1;
            ifid_pc_nxt    = pc;
            ifid_instr_nxt = imem_rdata;
        end else if (ifid_valid & ifid_ready) begin
            ifid_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_BOOT;
            pc         <= RESET_PC;
            ifid_valid <= 1'b0;
            ifid_pc    <= '0;
            ifid_instr <= '0;
            flush_out  <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            ifid_valid <= ifid_valid_nxt;
            ifid_pc    <= ifid_pc_nxt;
            ifid_instr <= ifid_instr_nxt;
            flush_out  <= flush_nxt;
        end
    end

`ifdef IF_MISALIGN_TRAP_EN
    // Sticky trap flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign <= 1'b0;
        end else if (redirect && (target[1:0] != 2'b00)) begin
            misalign <= 1'b1;
        end
    end
`else
    assign misalign = 1'b0;
`endif

endmodule
